// File: rtl/key_debounce.sv
// key_debounce: synchronises a raw switch vector and commits a new key only
// after it has stayed unchanged for STABLE_CYCLES further synchronised samples.
// Emits a one-cycle key_change pulse alongside every commit.
module key_debounce #(
    parameter int unsigned KEY_LEN       = 2,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_LEN-1:0] sw_in,
    output logic [KEY_LEN-1:0] key,
    output logic               key_valid,
    output logic               key_change
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_STABLE,
        ST_SETTLING
    } state_e;

    logic [SYNC_STAGES-1:0][KEY_LEN-1:0] sync_q, sync_d;
    logic [KEY_LEN-1:0] sampled;

    state_e             state_q, state_d;
    logic [KEY_LEN-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_LEN-1:0] key_q, key_d;
    logic               valid_q, valid_d;
    logic               change_q, change_d;

    // Synchroniser chain: stage 0 captures sw_in, last stage feeds the FSM.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
    end

    assign sampled = sync_q[SYNC_STAGES-1];

    // Next-state, candidate/count tracking and commit decision.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        valid_d  = valid_q;
        change_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (sampled != cand_q) begin
                    cand_d = sampled;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    key_d    = cand_q;
                    valid_d  = 1'b1;
                    change_d = 1'b1;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (sampled != key_q) begin
                    cand_d  = sampled;
                    cnt_d   = '0;
                    state_d = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (sampled == key_q) begin
                    // input fell back to the current key: glitch, no commit
                    state_d = ST_STABLE;
                end else if (sampled != cand_q) begin
                    cand_d = sampled;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    key_d    = cand_q;
                    change_d = 1'b1;
                    state_d  = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= ST_INIT;
            cand_q   <= '0;
            cnt_q    <= '0;
            key_q    <= '0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            change_q <= change_d;
        end
    end

    assign key        = key_q;
    assign key_valid  = valid_q;
    assign key_change = change_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed per-cycle vector table on the default
// configuration, a hand sequence on a STABLE_CYCLES=1 instance, and random
// switch activity checked against a run-length reference model.
module tb_key_debounce;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic [1:0] key0, key1;
    logic       valid0, valid1;
    logic       chg0, chg1;

    int n_vec;
    int n_err;

    key_debounce #(
        .KEY_LEN(2),
        .SYNC_STAGES(SYNC),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw),
        .key(key0),
        .key_valid(valid0),
        .key_change(chg0)
    );

    key_debounce #(
        .KEY_LEN(2),
        .SYNC_STAGES(SYNC),
        .STABLE_CYCLES(1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .sw_in(sw),
        .key(key1),
        .key_valid(valid1),
        .key_change(chg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sampled value is sw delayed by SYNC edges (zero after reset).
    // A value is committed once the most recent STABLE_CYCLES+1 samples all
    // equal it and it differs from the current key (or nothing is accepted yet).
    // Reset counts as one virtual sample of zero.
    typedef struct {
        logic [SYNC-1:0][1:0] dl;
        logic [1:0]           run_val;
        int                   run_len;
        logic [1:0]           key;
        logic                 valid;
        logic                 chg;
    } model_t;

    model_t m0, m1;

    task automatic model_step(inout model_t m, input int stable, input logic r, input logic [1:0] s);
        logic [1:0] samp;
        if (r) begin
            m.dl      = '0;
            m.run_val = 2'b00;
            m.run_len = 1;
            m.key     = 2'b00;
            m.valid   = 1'b0;
            m.chg     = 1'b0;
        end else begin
            samp = m.dl[SYNC-1];
            m.dl = {m.dl[SYNC-2:0], s};
            if (samp == m.run_val) begin
                m.run_len = m.run_len + 1;
            end else begin
                m.run_val = samp;
                m.run_len = 1;
            end
            m.chg = 1'b0;
            if (m.run_len >= stable + 1 && (!m.valid || m.run_val != m.key)) begin
                m.key   = m.run_val;
                m.valid = 1'b1;
                m.chg   = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs away from the edge, step models, check #1 after.
    task automatic cycle(input logic r, input logic [1:0] s);
        @(negedge clk);
        rst = r;
        sw  = s;
        @(posedge clk);
        model_step(m0, 4, r, s);
        model_step(m1, 1, r, s);
        #1;
        check("m0_key",   {6'd0, key0},   {6'd0, m0.key});
        check("m0_valid", {7'd0, valid0}, {7'd0, m0.valid});
        check("m0_chg",   {7'd0, chg0},   {7'd0, m0.chg});
        check("m1_key",   {6'd0, key1},   {6'd0, m1.key});
        check("m1_valid", {7'd0, valid1}, {7'd0, m1.valid});
        check("m1_chg",   {7'd0, chg1},   {7'd0, m1.chg});
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] sw;
        logic [1:0] key;
        logic       valid;
        logic       chg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] s, input logic [1:0] k,
                       input logic v, input logic c, input int n);
        vec_t e;
        e.rst = r; e.sw = s; e.key = k; e.valid = v; e.chg = c;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        sw    = 2'b00;

        // reset, then INIT commits 00 on the 4th edge after release
        add(1, 2'b00, 2'b00, 0, 0, 2);
        add(0, 2'b00, 2'b00, 0, 0, 3);
        add(0, 2'b00, 2'b00, 1, 1, 1);
        add(0, 2'b00, 2'b00, 1, 0, 3);
        // 11 for 3 cycles then back to 00: glitch rejected
        add(0, 2'b11, 2'b00, 1, 0, 3);
        add(0, 2'b00, 2'b00, 1, 0, 8);
        // clean step to 10: key updates on edge 7, single pulse
        add(0, 2'b10, 2'b00, 1, 0, 6);
        add(0, 2'b10, 2'b10, 1, 1, 1);
        add(0, 2'b10, 2'b10, 1, 0, 3);
        // bounce 01,01,10,01 then 11 held: only 11 is committed
        add(0, 2'b01, 2'b10, 1, 0, 2);
        add(0, 2'b10, 2'b10, 1, 0, 1);
        add(0, 2'b01, 2'b10, 1, 0, 1);
        add(0, 2'b11, 2'b10, 1, 0, 6);
        add(0, 2'b11, 2'b11, 1, 1, 1);
        add(0, 2'b11, 2'b11, 1, 0, 3);
        // reset two cycles into settling toward 01, INIT then commits 01
        add(0, 2'b01, 2'b11, 1, 0, 4);
        add(1, 2'b01, 2'b00, 0, 0, 1);
        add(0, 2'b01, 2'b00, 0, 0, 6);
        add(0, 2'b01, 2'b01, 1, 1, 1);
        add(0, 2'b01, 2'b01, 1, 0, 2);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].sw);
            check($sformatf("tbl%0d_key", i),   {6'd0, key0},   {6'd0, tbl[i].key});
            check($sformatf("tbl%0d_valid", i), {7'd0, valid0}, {7'd0, tbl[i].valid});
            check($sformatf("tbl%0d_chg", i),   {7'd0, chg0},   {7'd0, tbl[i].chg});
        end

        // STABLE_CYCLES=1: INIT commits on first edge; step to 11 lands on edge 4
        cycle(1, 2'b00);
        cycle(1, 2'b00);
        cycle(0, 2'b00);
        check("s1_init_valid", {7'd0, valid1}, 8'd1);
        check("s1_init_chg",   {7'd0, chg1},   8'd1);
        cycle(0, 2'b00);
        cycle(0, 2'b00);
        for (int i = 1; i <= 5; i++) begin
            cycle(0, 2'b11);
            check($sformatf("s1_step%0d_key", i), {6'd0, key1},
                  (i >= 4) ? 8'd3 : 8'd0);
            check($sformatf("s1_step%0d_chg", i), {7'd0, chg1},
                  (i == 4) ? 8'd1 : 8'd0);
        end
        cycle(0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 2'b11);
            check($sformatf("s1_glitch%0d_key", i), {6'd0, key1}, 8'd3);
            check($sformatf("s1_glitch%0d_chg", i), {7'd0, chg1}, 8'd0);
        end

        // random switch activity with occasional resets
        for (int i = 0; i < 3000; ) begin
            int          hold;
            logic [1:0]  v;
            hold = $urandom_range(1, 9);
            v    = 2'($urandom_range(0, 3));
            for (int j = 0; j < hold; j++) begin
                cycle($urandom_range(0, 199) == 0, v);
            end
            i += hold;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
